// File: rtl/uart_rx_port_pkg.sv
// Shared UART receive-side definitions: character length, RX deframer states
// and default widths used by uart_rx_port and its FIFO.
package uart_rx_port_pkg;

  localparam int UART_DEFAULT_DATA_LEN         = 8;
  localparam int UART_DEFAULT_BAUD_PERIOD_BITS = 16;
  localparam int UART_DEFAULT_FIFO_DEPTH_LOG2  = 3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO; head is valid the cycle after a push lands, pops advance next cycle.
// No backpressure of its own: push while full is ignored unless a pop happens in the same cycle.
module uart_rx_sync_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             not_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);
  assign do_pop    = pop & not_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push & (~full | do_pop);
  assign head_dat  = not_empty ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver: 2-flop RXD sync, mid-bit sampling deframer, show-ahead byte FIFO; byte visible 1 clk after stop sample.
// No backpressure to the line: a byte arriving while the FIFO is full is dropped and flagged as overrun.
module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int BAUD_PERIOD_BITS = UART_DEFAULT_BAUD_PERIOD_BITS,
  parameter int FIFO_DEPTH_LOG2  = UART_DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic                        clk,
  input  logic                        sync_reset,
  input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
  input  logic                        RXD,
  input  logic                        fifo_read_req,
  input  logic                        clear_errors,
  output logic [7:0]                  rx_data_out,
  output logic                        rx_fifo_not_empty,
  output logic                        rx_fifo_full,
  output logic                        overrun_err,
  output logic                        frame_err,
  output logic                        rx_int_req
);

  localparam int DATA_LEN  = UART_DEFAULT_DATA_LEN;
  localparam int BIT_IDX_W = $clog2(DATA_LEN);
  localparam logic [BIT_IDX_W-1:0]        LAST_BIT = BIT_IDX_W'(DATA_LEN - 1);
  localparam logic [BIT_IDX_W-1:0]        IDX_ONE  = BIT_IDX_W'(1);
  localparam logic [BAUD_PERIOD_BITS-1:0] CNT_ONE  = BAUD_PERIOD_BITS'(1);

  logic                        rxd_meta_q, rxd_meta_d;
  logic                        rxd_s_q, rxd_s_d;
  logic                        rxd_prev_q, rxd_prev_d;
  logic                        rxd_s;
  rx_state_e                   state_q, state_d;
  logic [BAUD_PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [BAUD_PERIOD_BITS-1:0] period_q, period_d;
  logic [BIT_IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_LEN-1:0]         shift_q, shift_d;
  logic                        overrun_q, overrun_d;
  logic                        frame_err_q, frame_err_d;
  logic                        push, frame_set, overrun_set;
  logic                        fifo_full, fifo_not_empty;

  assign rxd_s      = rxd_s_q;
  assign rxd_meta_d = RXD;
  assign rxd_s_d    = rxd_meta_q;
  assign rxd_prev_d = rxd_s_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rxd_prev_q & ~rxd_s) begin
          period_d = baud_rate_period_m1;
          cnt_d    = '0;
          state_d  = RX_START;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == (period_q >> 1)) begin
          cnt_d = '0;
          if (!rxd_s) begin
            bit_idx_d = '0;
            state_d   = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == period_q) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[DATA_LEN-1:1]};
          bit_idx_d = bit_idx_q + IDX_ONE;
          if (bit_idx_q == LAST_BIT) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        // Leave at mid stop bit so a start edge in its second half is caught.
        if (cnt_q == period_q) begin
          cnt_d     = '0;
          state_d   = RX_IDLE;
          push      = rxd_s;
          frame_set = ~rxd_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign overrun_set = push & fifo_full & ~fifo_read_req;
  assign overrun_d   = overrun_set | (overrun_q & ~clear_errors);
  assign frame_err_d = frame_set | (frame_err_q & ~clear_errors);

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_prev_q  <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd_meta_d;
      rxd_s_q     <= rxd_s_d;
      rxd_prev_q  <= rxd_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_rx_sync_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (DATA_LEN)
  ) u_fifo (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (push),
    .push_dat   (shift_q),
    .pop        (fifo_read_req),
    .head_dat   (rx_data_out),
    .full       (fifo_full),
    .not_empty  (fifo_not_empty)
  );

  assign rx_fifo_full      = fifo_full;
  assign rx_fifo_not_empty = fifo_not_empty;
  assign overrun_err       = overrun_q;
  assign frame_err         = frame_err_q;
  assign rx_int_req        = fifo_not_empty | overrun_q | frame_err_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: serial frames driven on RXD at 16 clocks/bit,
// expected bytes kept in a scoreboard queue and compared as they are popped.
module tb_uart_rx_port;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [15:0] baud_rate_period_m1;
  logic        RXD;
  logic        fifo_read_req;
  logic        clear_errors;
  logic [7:0]  rx_data_out;
  logic        rx_fifo_not_empty;
  logic        rx_fifo_full;
  logic        overrun_err;
  logic        frame_err;
  logic        rx_int_req;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  sb [$];
  logic        exp_overrun = 1'b0;
  logic        exp_frame   = 1'b0;

  always #5 clk = ~clk;

  uart_rx_port dut (
    .clk                 (clk),
    .sync_reset          (sync_reset),
    .baud_rate_period_m1 (baud_rate_period_m1),
    .RXD                 (RXD),
    .fifo_read_req       (fifo_read_req),
    .clear_errors        (clear_errors),
    .rx_data_out         (rx_data_out),
    .rx_fifo_not_empty   (rx_fifo_not_empty),
    .rx_fifo_full        (rx_fifo_full),
    .overrun_err         (overrun_err),
    .frame_err           (frame_err),
    .rx_int_req          (rx_int_req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model occupancy is the scoreboard size; a ninth byte means overrun.
  task automatic expect_byte(input logic [7:0] b);
    if (sb.size() < 8) sb.push_back(b);
    else exp_overrun = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    @(negedge clk);
    check({tag, "_not_empty"}, rx_fifo_not_empty, (sb.size() != 0));
    check({tag, "_full"},      rx_fifo_full,      (sb.size() == 8));
    check({tag, "_overrun"},   overrun_err,       exp_overrun);
    check({tag, "_frame"},     frame_err,         exp_frame);
    check({tag, "_int_req"},   rx_int_req,        (sb.size() != 0) | exp_overrun | exp_frame);
    if (sb.size() != 0) check({tag, "_head"}, rx_data_out, sb[0]);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    @(negedge clk);
    check({tag, "_pop_vld"}, rx_fifo_not_empty, 1);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    check({tag, "_pop_dat"}, rx_data_out, exp);
    fifo_read_req = 1'b1;
    @(negedge clk);
    fifo_read_req = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    exp_overrun = 1'b0;
    exp_frame   = 1'b0;
  endtask

  // One 8N1 frame, 160 clocks. The stop sample lands in the cycle after
  // negedge 154, so the byte must be visible at negedge 155 and not before.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input bit check_vis, input bit pop_at_stop, input int rst_at);
    logic [7:0] hd;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (check_vis && i == 154) check("vis_before", rx_fifo_not_empty, 0);
      if (check_vis && i == 155) begin
        check("vis_not_empty", rx_fifo_not_empty, 1);
        check("vis_data",      rx_data_out,       b);
        check("vis_int_req",   rx_int_req,        1);
      end
      if (pop_at_stop && i == 154) begin
        hd = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        check("simul_head", rx_data_out, hd);
        fifo_read_req = 1'b1;
      end
      if (i == 155) fifo_read_req = 1'b0;
      if (i == rst_at) begin
        sync_reset = 1'b1;
        RXD        = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        check("rst_mid_data",      rx_data_out,       0);
        check("rst_mid_not_empty", rx_fifo_not_empty, 0);
        check("rst_mid_full",      rx_fifo_full,      0);
        check("rst_mid_overrun",   overrun_err,       0);
        check("rst_mid_frame",     frame_err,         0);
        check("rst_mid_int_req",   rx_int_req,        0);
        sb.delete();
        exp_overrun = 1'b0;
        exp_frame   = 1'b0;
        return;
      end
      if (i < 16)       RXD = 1'b0;
      else if (i < 144) RXD = b[(i - 16) / 16];
      else              RXD = stop_val;
    end
  endtask

  initial begin
    sync_reset          = 1'b1;
    baud_rate_period_m1 = 16'd15;
    RXD                 = 1'b1;
    fifo_read_req       = 1'b0;
    clear_errors        = 1'b0;
    idle(3);
    check("reset_data",      rx_data_out,       0);
    check("reset_not_empty", rx_fifo_not_empty, 0);
    check("reset_full",      rx_fifo_full,      0);
    check("reset_overrun",   overrun_err,       0);
    check("reset_frame",     frame_err,         0);
    check("reset_int_req",   rx_int_req,        0);
    sync_reset = 1'b0;
    idle(5);

    // Single byte with exact visibility timing.
    send_frame(8'hA5, 1'b1, 1, 0, -1);
    expect_byte(8'hA5);
    check_flags("single");
    pop_check("single");
    check_flags("single_after_pop");

    // Back-to-back frames with zero idle.
    send_frame(8'h00, 1'b1, 0, 0, -1); expect_byte(8'h00);
    send_frame(8'hFF, 1'b1, 0, 0, -1); expect_byte(8'hFF);
    send_frame(8'h5A, 1'b1, 0, 0, -1); expect_byte(8'h5A);
    idle(20);
    check_flags("b2b");
    repeat (3) pop_check("b2b");
    check_flags("b2b_drained");

    // Overrun: nine bytes, no pops.
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b1, 0, 0, -1);
      expect_byte(8'(k));
      if (k == 8) check_flags("ovr_full8");
    end
    idle(20);
    check_flags("ovr");
    repeat (8) pop_check("ovr");
    check_flags("ovr_drained");
    pulse_clear();
    check_flags("ovr_cleared");

    // Framing error, then a short glitch.
    send_frame(8'h3C, 1'b0, 0, 0, -1);
    RXD = 1'b1;
    exp_frame = 1'b1;
    idle(20);
    check_flags("frame");
    pulse_clear();
    check_flags("frame_cleared");
    @(negedge clk);
    RXD = 1'b0;
    idle(4);
    RXD = 1'b1;
    idle(40);
    check_flags("glitch");

    // Full FIFO with push and pop in the same cycle.
    for (int k = 0; k < 8; k++) begin
      send_frame(8'h10 + 8'(k), 1'b1, 0, 0, -1);
      expect_byte(8'h10 + 8'(k));
    end
    send_frame(8'h99, 1'b1, 0, 1, -1);
    expect_byte(8'h99);
    idle(20);
    check_flags("simul");
    repeat (8) pop_check("simul");
    check_flags("simul_drained");

    // Reset during data bit 4 with a byte buffered and a flag set.
    send_frame(8'h42, 1'b0, 0, 0, -1);
    RXD = 1'b1;
    exp_frame = 1'b1;
    idle(20);
    send_frame(8'h77, 1'b1, 0, 0, -1);
    expect_byte(8'h77);
    idle(20);
    check_flags("pre_rst");
    send_frame(8'hC3, 1'b1, 0, 0, 88);
    idle(40);
    check_flags("post_rst");
    send_frame(8'h81, 1'b1, 0, 0, -1);
    expect_byte(8'h81);
    idle(20);
    check_flags("after_rst");
    pop_check("after_rst");
    check_flags("after_rst_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
